sub_pipe_16bits: RTL and testbench
==================================

SUB_PIPE_16BITS -- requirements
Module: sub_pipe_16bits

Interface
REQ-001 The block SHALL have no parameters; width (16) and depth (4 stages, one nibble per stage) are fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand set a/b/bin presented this cycle.
REQ-005 in_ready  output  1  block accepts the operand set this cycle.
REQ-006 a  input  16  minuend, unsigned or two's complement.
REQ-007 b  input  16  subtrahend.
REQ-008 bin  input  1  borrow-in.
REQ-009 out_valid  output  1  d/bout (and flags) valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 d  output  16  difference a - b - bin, modulo 2^16.
REQ-012 bout  output  1  borrow-out; 1 iff unsigned a < b + bin.
REQ-013 zf, nf, vf  output  1 each  zero, negative and signed-overflow flags; present only with SUB_FLAGS_EN.

Function
REQ-014 Stage k (k=0..3) SHALL compute nibble k of d with a 4-bit borrow-lookahead, taking borrow from stage k-1 (bin for stage 0), and SHALL register its nibble result, its borrow and the not-yet-used operand nibbles.
REQ-015 Transfer SHALL occur at an input when in_valid && in_ready and at the output when out_valid && out_ready.
REQ-016 Latency SHALL be exactly 4 cycles from input transfer to out_valid with no stall; throughput SHALL be one result per cycle.
REQ-017 Stall SHALL be global: adv = !(out_valid && !out_ready); in_ready = adv; when adv = 0 every stage register, including valid bits, SHALL hold.
REQ-018 in_ready SHALL depend combinationally only on out_valid and out_ready, never on in_valid.
REQ-019 Bubbles (in_valid = 0 while adv = 1) SHALL propagate as cleared stage valid bits; d/bout are don't-care when out_valid = 0 but SHALL be held stable while out_valid = 1 and out_ready = 0.
REQ-020 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-021 Simultaneous output transfer and input transfer in the same cycle SHALL be supported with no bubble.
REQ-022 bout SHALL equal the borrow out of bit 15; a = b with bin = 1 SHALL give d = 0xFFFF, bout = 1.

Reset
REQ-023 On rst_n low, all stage valid bits SHALL clear immediately (asynchronous), out_valid = 0 and in_ready = 1; d, bout and the flags SHALL read 0.
REQ-024 In-flight operations at reset SHALL be discarded; the first operation after release SHALL produce a result after exactly 4 cycles.
REQ-025 Reset deassertion SHALL be taken synchronously to clk by the surrounding system; the block SHALL not add a synchronizer.

Configuration
REQ-026 Macro SUB_FLAGS_EN: when defined, zf = (d == 0), nf = d[15], vf = (a[15] != b[15]) && (d[15] != a[15]), all registered alongside d; a[15] SHALL be carried down the pipeline for this.
REQ-027 Without SUB_FLAGS_EN, ports zf/nf/vf and the associated registers SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-028 Reset then a=0x1234, b=0x0234, bin=0, out_ready=1 -> after 4 cycles d=0x1000, bout=0, out_valid=1 for one cycle.
REQ-029 a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1; with SUB_FLAGS_EN: nf=1, zf=0, vf=0.
REQ-030 a=0x8000, b=0x0001 -> d=0x7FFF, bout=0, vf=1; a=0x5555, b=0x5555, bin=0 -> d=0, zf=1.
REQ-031 Stream 8 back-to-back operands, out_ready low for cycles 5-7 -> in_ready low in the same cycles, out_valid/d held, all 8 results delivered in order, none lost.
REQ-032 Assert rst_n low mid-stream with 3 operations in flight -> out_valid drops immediately, no stale result after release; a new operand produces its result 4 cycles later.
REQ-033 10,000 random a/b/bin with random in_valid/out_ready -> every d/bout matches a scoreboard model of a - b - bin.

Source files
------------

// File: rtl/sub_pipe_16bits.sv
// 16-bit subtractor, four nibble stages with borrow lookahead and a global valid/ready stall.
// Optional zero/negative/overflow flags are built only when SUB_FLAGS_EN is defined.
module sub_pipe_16bits (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] d,
  output logic        bout
`ifdef SUB_FLAGS_EN
  ,
  output logic        zf,
  output logic        nf,
  output logic        vf
`endif
);

  localparam int unsigned W  = 16;
  localparam int unsigned NB = 4;

  // Nibble subtract x - y - bi; returns {borrow_out, difference}.
  function automatic logic [NB:0] nib_sub(input logic [NB-1:0] x, input logic [NB-1:0] y,
                                          input logic bi);
    logic [NB-1:0] g;
    logic [NB-1:0] p;
    logic [NB:0]   c;
    g    = ~x & y;
    p    = ~(x ^ y);
    c[0] = bi;
    c[1] = g[0] | (p[0] & bi);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (&p & bi);
    return {c[NB], x ^ y ^ c[NB-1:0]};
  endfunction

  logic          adv;
  logic          v0, v1, v2, v3;
  logic          br0, br1, br2;
  logic [3:0]    d0;
  logic [7:0]    d1;
  logic [11:0]   d2;
  logic [15:4]   a0, b0;
  logic [15:8]   a1, b1;
  logic [15:12]  a2, b2;
  logic [NB:0]   r0, r1, r2, r3;
  logic [W-1:0]  d_nxt;

  // Global stall: everything holds while a result waits at the output.
  assign adv       = !(v3 && !out_ready);
  assign in_ready  = adv;
  assign out_valid = v3;

  assign r0    = nib_sub(a[3:0],   b[3:0],   bin);
  assign r1    = nib_sub(a0[7:4],  b0[7:4],  br0);
  assign r2    = nib_sub(a1[11:8], b1[11:8], br1);
  assign r3    = nib_sub(a2[15:12], b2[15:12], br2);
  assign d_nxt = {r3[NB-1:0], d2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0   <= 1'b0;
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      d0   <= '0;
      d1   <= '0;
      d2   <= '0;
      d    <= '0;
      br0  <= 1'b0;
      br1  <= 1'b0;
      br2  <= 1'b0;
      bout <= 1'b0;
      a0   <= '0;
      b0   <= '0;
      a1   <= '0;
      b1   <= '0;
      a2   <= '0;
      b2   <= '0;
    end else if (adv) begin
      v0   <= in_valid;
      d0   <= r0[NB-1:0];
      br0  <= r0[NB];
      a0   <= a[15:4];
      b0   <= b[15:4];
      v1   <= v0;
      d1   <= {r1[NB-1:0], d0};
      br1  <= r1[NB];
      a1   <= a0[15:8];
      b1   <= b0[15:8];
      v2   <= v1;
      d2   <= {r2[NB-1:0], d1};
      br2  <= r2[NB];
      a2   <= a1[15:12];
      b2   <= b1[15:12];
      v3   <= v2;
      d    <= d_nxt;
      bout <= r3[NB];
    end
  end

`ifdef SUB_FLAGS_EN
  // Flags use the sign bits still carried in the last stage's operand nibbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf <= 1'b0;
      nf <= 1'b0;
      vf <= 1'b0;
    end else if (adv) begin
      zf <= (d_nxt == '0);
      nf <= d_nxt[W-1];
      vf <= (a2[15] != b2[15]) && (d_nxt[W-1] != a2[15]);
    end
  end
`endif

endmodule

// File: tb/tb_sub_pipe_16bits.sv
// Bench for sub_pipe_16bits: vector table, stall/reset sequences and a random scoreboard run.
// Flag checks are compiled in when SUB_FLAGS_EN is defined.
module tb_sub_pipe_16bits;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] d;
  logic        bout;
`ifdef SUB_FLAGS_EN
  logic        zf, nf, vf;
`endif

  sub_pipe_16bits dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout)
`ifdef SUB_FLAGS_EN
    ,
    .zf        (zf),
    .nf        (nf),
    .vf        (vf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        bout;
    logic        zf;
    logic        nf;
    logic        vf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    exp_t        e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  exp_t sb[$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_d;
  logic        prev_bout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic bi);
    exp_t        e;
    logic [16:0] r;
    r      = {1'b0, x} - {1'b0, y} - 17'(bi);
    e.d    = r[15:0];
    e.bout = r[16];
    e.zf   = (r[15:0] == 16'h0);
    e.nf   = r[15];
    e.vf   = (x[15] != y[15]) && (r[15] != x[15]);
    return e;
  endfunction

  // Scoreboard, handshake rule and stall-hold monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_d", 32'(d), 32'(prev_d));
        check("hold_bout", 32'(bout), 32'(prev_bout));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_d", 32'(d), 32'(e.d));
          check("sb_bout", 32'(bout), 32'(e.bout));
`ifdef SUB_FLAGS_EN
          check("sb_zf", 32'(zf), 32'(e.zf));
          check("sb_nf", 32'(nf), 32'(e.nf));
          check("sb_vf", 32'(vf), 32'(e.vf));
`endif
        end
        pops++;
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, bin));
      prev_stall = out_valid && !out_ready;
      prev_d     = d;
      prev_bout  = bout;
    end
  end

  // Single operand into an idle pipe; checks latency, result and one-cycle valid.
  task automatic run_vec(input vec_t v);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    a = v.a; b = v.b; bin = v.bin; in_valid = 1'b1; out_ready = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check("vec_latency", 32'(lat), 32'd4);
    check("vec_d", 32'(d), 32'(v.e.d));
    check("vec_bout", 32'(bout), 32'(v.e.bout));
`ifdef SUB_FLAGS_EN
    check("vec_zf", 32'(zf), 32'(v.e.zf));
    check("vec_nf", 32'(nf), 32'(v.e.nf));
    check("vec_vf", 32'(vf), 32'(v.e.vf));
`endif
    @(posedge clk); #1;
    @(negedge clk);
    check("vec_one_cycle", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   sent;
    int   start;

    //          a         b         bin   d         bout  zf    nf    vf
    vecs[0] = '{16'h1234, 16'h0234, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[3] = '{16'h5555, 16'h5555, 1'b0, '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[4] = '{16'h1234, 16'h1234, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, '{16'h8000, 1'b1, 1'b0, 1'b1, 1'b1}};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[7] = '{16'hFFFF, 16'h0001, 1'b1, '{16'hFFFD, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[8] = '{16'hABCD, 16'h1234, 1'b0, '{16'h9999, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[9] = '{16'h0F0F, 16'h00F0, 1'b1, '{16'h0E1E, 1'b0, 1'b0, 1'b0, 1'b0}};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_d", 32'(d), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    @(negedge clk); @(negedge clk); #2;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Eight back-to-back operands with the output stalled in cycles 5..7.
    sent  = 0;
    start = pops;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 5 && c <= 7);
      if (sent < 8) begin
        in_valid = 1'b1;
        a   = 16'(sent * 16'h1111 + 16'h0007);
        b   = 16'(16'h2222 - sent * 16'h0101);
        bin = sent[0];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 5 && c <= 7) check("stall_in_ready", 32'(in_ready), 32'd0);
      if (in_valid && in_ready) sent++;
      if (sent == 8 && pops - start == 8) break;
    end
    check("stall_sent", 32'(sent), 32'd8);
    check("stall_delivered", 32'(pops - start), 32'd8);

    // Reset with operations in flight.
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a = 16'(16'h4000 + c); b = 16'(c); bin = 1'b0;
    end
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_d", 32'(d), 32'd0);
    check("mid_rst_bout", 32'(bout), 32'd0);
    @(negedge clk); @(negedge clk); #2;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    run_vec(vecs[8]);

    // Random traffic checked by the scoreboard.
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      a   = 16'($urandom);
      b   = 16'($urandom);
      bin = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
